// File: rtl/data_mem_access_pkg.sv
// Shared encodings for the data-memory initiator: access sizes, FSM states,
// and the alignment rule applied when a request is accepted.
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STORE  = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    RESP   = 3'd5
  } state_e;

  // Size 3 is never legal; halves need even addresses, words need offset 0.
  function automatic logic req_illegal(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = offset[0];
      SZ_WORD: bad = (offset != 2'd0);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/data_mem_access_lane_align.sv
// Big-endian lane handling: extracts and extends load lanes, and merges
// right-aligned store data into a memory word for sub-word stores.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        is_unsigned_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merged_o
);

  logic [4:0]  shamt;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    // Offset 0 lives in bits [31:24], so the lane LSB sits at 8*(3-offset).
    shamt     = {~offset_i, 3'b000};
    byte_lane = 8'(word_i >> shamt);
    half_lane = offset_i[1] ? word_i[15:0] : word_i[31:16];

    case (size_i)
      SZ_BYTE: load_o = is_unsigned_i ? {24'd0, byte_lane}
                                      : {{24{byte_lane[7]}}, byte_lane};
      SZ_HALF: load_o = is_unsigned_i ? {16'd0, half_lane}
                                      : {{16{half_lane[15]}}, half_lane};
      default: load_o = word_i;
    endcase

    case (size_i)
      SZ_BYTE: merged_o = (word_i & ~(32'h0000_00FF << shamt))
                        | ({24'd0, wdata_i[7:0]} << shamt);
      SZ_HALF: merged_o = offset_i[1] ? {word_i[31:16], wdata_i[15:0]}
                                      : {wdata_i[15:0], word_i[15:0]};
      default: merged_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/data_mem_access.sv
// CPU-side initiator for the word-organised data memory. Sub-word stores are
// turned into read-modify-write; all memory-side outputs are registered.
//
//   state  | meaning
//   IDLE   | req_ready high, waiting for a request
//   LOAD   | mem_read strobe; lane extracted at exit edge
//   STORE  | mem_write strobe with the full store word
//   RMW_RD | mem_read strobe; store lane merged at exit edge
//   RMW_WR | mem_write strobe with the merged word
//   RESP   | one-cycle resp_valid pulse
module data_mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [31:0]       mem_read_data
);

  state_e              state_q, state_d;
  logic                req_ready_q, req_ready_d;
  logic [1:0]          size_q, size_d;
  logic                unsigned_q, unsigned_d;
  logic [1:0]          offset_q, offset_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic [31:0]         mem_write_data_q, mem_write_data_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic                resp_valid_q, resp_valid_d;
  logic [31:0]         resp_rdata_q, resp_rdata_d;
  logic                resp_err_q, resp_err_d;

  logic                accept;
  logic [31:0]         load_val;
  logic [31:0]         merged_word;
  logic                unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  mem_lane_align u_align (
    .word_i        (mem_read_data),
    .offset_i      (offset_q),
    .size_i        (size_q),
    .is_unsigned_i (unsigned_q),
    .wdata_i       (wdata_q),
    .load_o        (load_val),
    .merged_o      (merged_word)
  );

  always_comb begin
    accept           = req_valid && req_ready_q;
    state_d          = state_q;
    req_ready_d      = 1'b0;
    size_d           = size_q;
    unsigned_d       = unsigned_q;
    offset_d         = offset_q;
    wdata_d          = wdata_q;
    mem_address_d    = mem_address_q;
    mem_write_data_d = mem_write_data_q;
    mem_read_d       = 1'b0;
    mem_write_d      = 1'b0;
    resp_valid_d     = 1'b0;
    resp_rdata_d     = 32'd0;
    resp_err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (accept) begin
          req_ready_d   = 1'b0;
          size_d        = req_size;
          unsigned_d    = req_unsigned;
          offset_d      = req_addr[1:0];
          wdata_d       = req_wdata;
          mem_address_d = req_addr[ADDR_W+1:2];
          if (req_illegal(req_size, req_addr[1:0])) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (!req_write) begin
            state_d    = LOAD;
            mem_read_d = 1'b1;
          end else if (req_size == SZ_WORD) begin
            state_d          = STORE;
            mem_write_d      = 1'b1;
            mem_write_data_d = req_wdata;
          end else begin
            state_d    = RMW_RD;
            mem_read_d = 1'b1;
          end
        end
      end
      LOAD: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = load_val;
      end
      STORE: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
      end
      RMW_RD: begin
        state_d          = RMW_WR;
        mem_write_d      = 1'b1;
        mem_write_data_d = merged_word;
      end
      RMW_WR: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
      end
      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      req_ready_q      <= 1'b1;
      size_q           <= 2'd0;
      unsigned_q       <= 1'b0;
      offset_q         <= 2'd0;
      wdata_q          <= 32'd0;
      mem_address_q    <= '0;
      mem_write_data_q <= 32'd0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      resp_valid_q     <= 1'b0;
      resp_rdata_q     <= 32'd0;
      resp_err_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      req_ready_q      <= req_ready_d;
      size_q           <= size_d;
      unsigned_q       <= unsigned_d;
      offset_q         <= offset_d;
      wdata_q          <= wdata_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
      mem_read_q       <= mem_read_d;
      mem_write_q      <= mem_write_d;
      resp_valid_q     <= resp_valid_d;
      resp_rdata_q     <= resp_rdata_d;
      resp_err_q       <= resp_err_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign resp_valid     = resp_valid_q;
  assign resp_rdata     = resp_rdata_q;
  assign resp_err       = resp_err_q;
  assign mem_address    = mem_address_q;
  assign mem_write_data = mem_write_data_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;

endmodule

// File: tb/tb_data_mem_access.sv
// Directed bench for data_mem_access: falling-edge memory model, request
// driver checking strobe timing, and a response scoreboard monitor.
module tb_data_mem_access;
  import mem_access_pkg::*;

  localparam int ADDR_W = 13;
  localparam int K_ERR  = 0;
  localparam int K_LOAD = 1;
  localparam int K_SW   = 2;
  localparam int K_SUB  = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [1:0]        req_size = 2'd0;
  logic              req_unsigned = 1'b0;
  logic [31:0]       req_addr = 32'd0;
  logic [31:0]       req_wdata = 32'd0;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_write_data;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_read_data = 32'd0;

  always #5 clk = ~clk;

  data_mem_access #(.ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_read_data  (mem_read_data)
  );

  // Data memory: samples pins and registers read_data on the falling edge.
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  initial for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'd0;
  always @(negedge clk) begin
    if (mem_write) mem[mem_address] <= mem_write_data;
    if (mem_read)  mem_read_data    <= mem[mem_address];
  end

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_rdata_q[$];
  logic        exp_err_q[$];
  logic [31:0] mon_rdata;
  logic        mon_err;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_read && mem_write) check1("rd_wr_exclusive", mem_write, 1'b0);
      if (resp_valid) begin
        if (exp_rdata_q.size() == 0) begin
          check1("unexpected_resp", resp_valid, 1'b0);
        end else begin
          mon_rdata = exp_rdata_q.pop_front();
          mon_err   = exp_err_q.pop_front();
          check32("resp_rdata", resp_rdata, mon_rdata);
          check1("resp_err", resp_err, mon_err);
        end
      end
    end
  end

  task automatic wait_ready(input string name);
    int n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check1({name, " ready"}, req_ready, 1'b1);
  endtask

  task automatic do_req(input string name, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic [31:0] exp_wword,
                        input int kind);
    logic [31:0] exp_addr;
    exp_addr = 32'(addr[ADDR_W+1:2]);
    wait_ready(name);
    req_valid    = 1'b1;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    exp_rdata_q.push_back(exp_rdata);
    exp_err_q.push_back(kind == K_ERR);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    case (kind)
      K_ERR: begin
        check1({name, " c1 rd"}, mem_read, 1'b0);
        check1({name, " c1 wr"}, mem_write, 1'b0);
        check1({name, " c1 resp_valid"}, resp_valid, 1'b1);
        @(negedge clk);
        check1({name, " c2 rd"}, mem_read, 1'b0);
        check1({name, " c2 wr"}, mem_write, 1'b0);
        check1({name, " c2 resp_valid"}, resp_valid, 1'b0);
      end
      K_LOAD: begin
        check1({name, " c1 rd"}, mem_read, 1'b1);
        check1({name, " c1 wr"}, mem_write, 1'b0);
        check32({name, " c1 addr"}, 32'(mem_address), exp_addr);
        check1({name, " c1 resp_valid"}, resp_valid, 1'b0);
        @(negedge clk);
        check1({name, " c2 rd"}, mem_read, 1'b0);
        check1({name, " c2 resp_valid"}, resp_valid, 1'b1);
      end
      K_SW: begin
        check1({name, " c1 wr"}, mem_write, 1'b1);
        check1({name, " c1 rd"}, mem_read, 1'b0);
        check32({name, " c1 addr"}, 32'(mem_address), exp_addr);
        check32({name, " c1 wdata"}, mem_write_data, exp_wword);
        check1({name, " c1 resp_valid"}, resp_valid, 1'b0);
        @(negedge clk);
        check1({name, " c2 wr"}, mem_write, 1'b0);
        check1({name, " c2 resp_valid"}, resp_valid, 1'b1);
      end
      default: begin
        check1({name, " c1 rd"}, mem_read, 1'b1);
        check1({name, " c1 wr"}, mem_write, 1'b0);
        check32({name, " c1 addr"}, 32'(mem_address), exp_addr);
        check1({name, " c1 resp_valid"}, resp_valid, 1'b0);
        @(negedge clk);
        check1({name, " c2 wr"}, mem_write, 1'b1);
        check1({name, " c2 rd"}, mem_read, 1'b0);
        check32({name, " c2 addr"}, 32'(mem_address), exp_addr);
        check32({name, " c2 wdata"}, mem_write_data, exp_wword);
        check1({name, " c2 resp_valid"}, resp_valid, 1'b0);
        @(negedge clk);
        check1({name, " c3 wr"}, mem_write, 1'b0);
        check1({name, " c3 resp_valid"}, resp_valid, 1'b1);
      end
    endcase
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check1("reset req_ready", req_ready, 1'b1);
    check1("reset resp_valid", resp_valid, 1'b0);
    check1("reset mem_read", mem_read, 1'b0);
    check1("reset mem_write", mem_write, 1'b0);
    check32("reset mem_address", 32'(mem_address), 32'd0);
    check32("reset resp_rdata", resp_rdata, 32'd0);
    check1("reset resp_err", resp_err, 1'b0);
    rst = 1'b0;

    //      name        wr    size     uns   addr   wdata          exp_rdata      exp_wword      kind
    do_req("sw0",       1'b1, SZ_WORD, 1'b0, 32'h0, 32'h12345678, 32'h0,        32'h12345678, K_SW);
    do_req("lw0",       1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0,        32'h12345678, 32'h0,        K_LOAD);
    do_req("lb3",       1'b0, SZ_BYTE, 1'b0, 32'h3, 32'h0,        32'h00000078, 32'h0,        K_LOAD);
    do_req("lb1",       1'b0, SZ_BYTE, 1'b0, 32'h1, 32'h0,        32'h00000034, 32'h0,        K_LOAD);
    do_req("lb0",       1'b0, SZ_BYTE, 1'b0, 32'h0, 32'h0,        32'h00000012, 32'h0,        K_LOAD);
    do_req("lh2",       1'b0, SZ_HALF, 1'b0, 32'h2, 32'h0,        32'h00005678, 32'h0,        K_LOAD);
    do_req("sw4",       1'b1, SZ_WORD, 1'b0, 32'h4, 32'h80000000, 32'h0,        32'h80000000, K_SW);
    do_req("lb4",       1'b0, SZ_BYTE, 1'b0, 32'h4, 32'h0,        32'hFFFFFF80, 32'h0,        K_LOAD);
    do_req("lbu4",      1'b0, SZ_BYTE, 1'b1, 32'h4, 32'h0,        32'h00000080, 32'h0,        K_LOAD);
    do_req("lh4",       1'b0, SZ_HALF, 1'b0, 32'h4, 32'h0,        32'hFFFF8000, 32'h0,        K_LOAD);
    do_req("lhu4",      1'b0, SZ_HALF, 1'b1, 32'h4, 32'h0,        32'h00008000, 32'h0,        K_LOAD);
    do_req("lw4_uns",   1'b0, SZ_WORD, 1'b1, 32'h4, 32'h0,        32'h80000000, 32'h0,        K_LOAD);
    do_req("sb2",       1'b1, SZ_BYTE, 1'b0, 32'h2, 32'h123456AB, 32'h0,        32'h1234AB78, K_SUB);
    do_req("lw0_sb",    1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0,        32'h1234AB78, 32'h0,        K_LOAD);
    do_req("sh0",       1'b1, SZ_HALF, 1'b0, 32'h0, 32'hDEADBEEF, 32'h0,        32'hBEEFAB78, K_SUB);
    do_req("lw0_sh",    1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0,        32'hBEEFAB78, 32'h0,        K_LOAD);
    do_req("sh6",       1'b1, SZ_HALF, 1'b0, 32'h6, 32'h00001111, 32'h0,        32'h80001111, K_SUB);
    do_req("lhu6",      1'b0, SZ_HALF, 1'b1, 32'h6, 32'h0,        32'h00001111, 32'h0,        K_LOAD);
    do_req("lb7",       1'b0, SZ_BYTE, 1'b0, 32'h7, 32'h0,        32'h00000011, 32'h0,        K_LOAD);
    do_req("sb5",       1'b1, SZ_BYTE, 1'b0, 32'h5, 32'h0000005A, 32'h0,        32'h805A1111, K_SUB);
    do_req("lw4_sb",    1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0,        32'h805A1111, 32'h0,        K_LOAD);
    do_req("err_lh1",   1'b0, SZ_HALF, 1'b0, 32'h1, 32'h0,        32'h0,        32'h0,        K_ERR);
    do_req("err_lw2",   1'b0, SZ_WORD, 1'b0, 32'h2, 32'h0,        32'h0,        32'h0,        K_ERR);
    do_req("err_sz3",   1'b0, 2'd3,    1'b0, 32'h0, 32'h0,        32'h0,        32'h0,        K_ERR);
    do_req("err_sw1",   1'b1, SZ_WORD, 1'b0, 32'h1, 32'hCAFEF00D, 32'h0,        32'h0,        K_ERR);
    do_req("err_sh3",   1'b1, SZ_HALF, 1'b0, 32'h3, 32'h0000CAFE, 32'h0,        32'h0,        K_ERR);
    do_req("lw0_err",   1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0,        32'hBEEFAB78, 32'h0,        K_LOAD);

    // Reset lands on the edge that ends RMW_RD: the store must vanish.
    wait_ready("rmw_rst");
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size  = SZ_BYTE;
    req_addr  = 32'h0;
    req_wdata = 32'h000000FF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check1("rmw_rst rd", mem_read, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check1("rmw_rst wr", mem_write, 1'b0);
    check1("rmw_rst resp_valid", resp_valid, 1'b0);
    check1("rmw_rst ready", req_ready, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    check1("rmw_rst wr later", mem_write, 1'b0);
    check1("rmw_rst resp later", resp_valid, 1'b0);
    do_req("lw0_rst",   1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0,        32'hBEEFAB78, 32'h0,        K_LOAD);

    repeat (3) @(negedge clk);
    check32("pending_resps", 32'(exp_rdata_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
